// File: rtl/rndswitch_pkg.sv
// Shared types and helpers for the random segment switch framer.
package rndswitch_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int frame_w(input int nb_frames);
    return (nb_frames > 1) ? $clog2(nb_frames) : 1;
  endfunction

endpackage

// File: rtl/rndswitch_outreg.sv
// Valid/ready output register slice holding one frame (mask, index, last flag).
module rndswitch_outreg #(
  parameter int W  = 70,
  parameter int IW = 3
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          load,
  input  logic [W-1:0]  mask_d,
  input  logic [IW-1:0] idx_d,
  input  logic          last_d,
  input  logic          out_ready,
  output logic          slot_free,
  output logic          out_valid,
  output logic [W-1:0]  out_mask,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  assign slot_free = !out_valid || out_ready;

  // Data only changes on load, so a stalled frame stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_mask  <= mask_d;
      out_idx   <= idx_d;
      out_last  <= last_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rndswitch_framer.sv
// Emits NB_FRAMES masked frames (seg & rnd) per accepted segment bitmap.
// Define RNDSWITCH_COVER_EN to force every lit segment into the last frame if not yet shown.
module rndswitch_framer
  import rndswitch_pkg::*;
#(
  parameter int NB_SEGMENTS = 70,
  parameter int NB_FRAMES   = 8,
  localparam int FRAME_W    = frame_w(NB_FRAMES)
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB_SEGMENTS-1:0] seg,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [NB_SEGMENTS-1:0] rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_SEGMENTS-1:0] out_mask,
  output logic [FRAME_W-1:0]     out_idx,
  output logic                   out_last
);

  // One extra bit so the count after the last frame does not wrap.
  localparam int CNT_W = $clog2(NB_FRAMES + 1);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       frame_cnt;
  logic [NB_SEGMENTS-1:0] seg_q;
  logic [NB_SEGMENTS-1:0] mask_d;
  logic                   slot_free;
  logic                   in_hs, rnd_hs, last_d;

  assign in_ready  = (state == IDLE) && !flush;
  assign rnd_ready = (state == RUN) && slot_free && !flush;
  assign in_hs     = in_valid && in_ready;
  assign rnd_hs    = rnd_valid && rnd_ready;
  assign last_d    = (frame_cnt == CNT_W'(NB_FRAMES - 1));

`ifdef RNDSWITCH_COVER_EN
  logic [NB_SEGMENTS-1:0] shown;

  assign mask_d = last_d ? (seg_q & (rnd | ~shown)) : (seg_q & rnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shown <= '0;
    else if (in_hs)  shown <= '0;
    else if (rnd_hs) shown <= shown | mask_d;
  end
`else
  assign mask_d = seg_q & rnd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      seg_q     <= '0;
    end else begin
      state <= state_n;
      if (flush || in_hs) frame_cnt <= '0;
      else if (rnd_hs)    frame_cnt <= frame_cnt + 1'b1;
      if (in_hs) seg_q <= seg;
    end
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_hs) state_n = RUN;
        RUN:     if (rnd_hs && last_d) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  rndswitch_outreg #(
    .W  (NB_SEGMENTS),
    .IW (FRAME_W)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (rnd_hs),
    .mask_d    (mask_d),
    .idx_d     (frame_cnt[FRAME_W-1:0]),
    .last_d    (last_d),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_mask  (out_mask),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

endmodule
